// File: rtl/ws2812_receiver.sv
// ws2812_receiver: single-wire NRZ LED-stream decoder; classifies high pulses by width,
// assembles MSB-first words and flags the low latch gap and stuck-high faults.
module ws2812_receiver #(
    parameter int W          = 24,
    parameter int T1_MIN     = 30,
    parameter int T_HIGH_MAX = 100,
    parameter int T_RESET    = 2500,
    parameter int CNT_W      = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         frame_end,
    output logic         err
);
    localparam int BW = $clog2(W + 1);
    localparam logic [CNT_W-1:0] T1   = CNT_W'(T1_MIN);
    localparam logic [CNT_W-1:0] THI  = CNT_W'(T_HIGH_MAX);
    localparam logic [CNT_W-1:0] TRS  = CNT_W'(T_RESET);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [BW-1:0]    LAST = BW'(W - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;
    state_t state, state_n;

    logic             s1, din_s, din_p;
    logic [CNT_W-1:0] hcnt, lcnt;
    logic [W-1:0]     shreg;
    logic [BW-1:0]    bcnt;
    logic             got_bit, rise, fall, bit_val, take, done, stuck, gap;

    assign rise    = din_s & ~din_p;
    assign fall    = ~din_s & din_p;
    assign bit_val = hcnt >= T1;

    // Sync flops reset high so a line held high across reset never looks like a rise
    always_ff @(posedge clk) begin
        if (rst) {s1, din_s, din_p} <= 3'b111;
        else     {s1, din_s, din_p} <= {din, s1, din_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            hcnt <= rise ? CNT_W'(1) : (din_s && hcnt != CMAX) ? hcnt + 1'b1 : hcnt;
            lcnt <= fall ? CNT_W'(1) : (!din_s && lcnt != CMAX) ? lcnt + 1'b1 : lcnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = rise ? HIGH : IDLE;
            HIGH:  state_n = fall ? LOW : (hcnt >= THI) ? STUCK : HIGH;
            LOW:   state_n = rise ? HIGH : gap ? IDLE : LOW;
            STUCK: state_n = fall ? LOW : STUCK;
        endcase
    end

    always_comb begin
        take  = state == HIGH && fall;
        done  = take && bcnt == LAST;
        stuck = state == HIGH && !fall && hcnt >= THI;
        gap   = state == LOW && lcnt == TRS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bcnt      <= '0;
            got_bit   <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_end <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid     <= done;
            frame_end <= gap && got_bit;
            err       <= stuck || (gap && bcnt != '0);
            bcnt      <= (done || stuck || gap) ? '0 : take ? bcnt + 1'b1 : bcnt;
            got_bit   <= take ? 1'b1 : gap ? 1'b0 : got_bit;
            if (take) shreg <= {shreg[W-2:0], bit_val};
            if (done) data <= {shreg[W-2:0], bit_val};
        end
    end
endmodule

// File: tb/tb_ws2812_receiver.sv
// tb_ws2812_receiver: directed and randomized pulse trains checked against a
// width-classification model and cycle timing derived from the line edges.
module tb_ws2812_receiver;
    localparam int TR  = 2500;
    localparam int THM = 100;
    localparam int T1  = 30;

    logic        clk = 1'b0, rst = 1'b1, din = 1'b0;
    logic [23:0] data;
    logic        valid, frame_end, err;

    ws2812_receiver dut (
        .clk(clk), .rst(rst), .din(din),
        .data(data), .valid(valid), .frame_end(frame_end), .err(err)
    );

    always #5 clk = ~clk;

    int          cyc = 0, tests = 0, fails = 0, hold_bad = 0, last_fall = 0, last_rise = 0;
    logic        rst_q = 1'b1;
    logic [23:0] prev = '0;
    logic [23:0] vq[$];
    int          vc[$], fc[$], ec[$];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Event recorder: every output pulse is logged with the cycle it was seen in
    always @(negedge clk) begin
        if (valid) begin
            vq.push_back(data);
            vc.push_back(cyc);
        end
        if (frame_end) fc.push_back(cyc);
        if (err) ec.push_back(cyc);
        if (!rst_q && !valid && data !== prev) hold_bad++;
        prev = data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        vq.delete();
        vc.delete();
        fc.delete();
        ec.delete();
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        din = 1'b1;
        last_rise = cyc;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(w[i], w[i] ? 40 : 20, w[i] ? 22 : 42);
    endtask

    task automatic gap();
        repeat (2600) @(negedge clk);
    endtask

    initial begin
        logic [23:0] exp_w;
        logic [23:0] words[4];
        int hi, lo;

        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_frame_end", 32'(frame_end), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        clear();

        // Single word
        send_word(24'hA5C3F0, 24);
        gap();
        check("single_nvalid", vq.size(), 1);
        check("single_data", (vq.size() > 0) ? 32'(vq[0]) : 32'hdead, 32'hA5C3F0);
        check("single_valid_cyc", (vc.size() > 0) ? vc[0] : -1, last_fall + 3);
        check("single_nframe", fc.size(), 1);
        check("single_frame_cyc", (fc.size() > 0) ? fc[0] : -1, last_fall + TR + 3);
        check("single_nerr", ec.size(), 0);
        clear();

        // Back-to-back words
        send_word(24'h00FF00, 24);
        send_word(24'hFFFFFF, 24);
        gap();
        check("b2b_nvalid", vq.size(), 2);
        check("b2b_first", (vq.size() > 0) ? 32'(vq[0]) : 32'hdead, 32'h00FF00);
        check("b2b_second", (vq.size() > 1) ? 32'(vq[1]) : 32'hdead, 32'hFFFFFF);
        check("b2b_nframe", fc.size(), 1);
        check("b2b_hold", 32'(data), 32'hFFFFFF);
        clear();

        // Threshold boundary: 29 cycles is a 0, 30 is a 1
        exp_w = '0;
        for (int i = 0; i < 24; i++) begin
            hi = (i % 2 == 0) ? 29 : 30;
            exp_w = {exp_w[22:0], hi >= T1};
            send_bit(hi >= T1, hi, 33);
        end
        gap();
        check("thr_nvalid", vq.size(), 1);
        check("thr_data", 32'(data), 32'(exp_w));
        clear();

        // Partial word then gap
        send_word(24'($urandom), 10);
        gap();
        check("part_nvalid", vq.size(), 0);
        check("part_nerr", ec.size(), 1);
        check("part_nframe", fc.size(), 1);
        check("part_same_cyc", (ec.size() > 0) ? ec[0] : -1, (fc.size() > 0) ? fc[0] : -2);
        check("part_frame_cyc", (fc.size() > 0) ? fc[0] : -1, last_fall + TR + 3);
        clear();
        send_word(24'h123456, 24);
        gap();
        check("after_part_data", (vq.size() > 0) ? 32'(vq[0]) : 32'hdead, 32'h123456);
        check("after_part_nerr", ec.size(), 0);
        clear();

        // Stuck-high line after 5 good bits
        send_word(24'($urandom), 5);
        din = 1'b1;
        last_rise = cyc;
        repeat (150) @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        gap();
        check("stuck_nerr", ec.size(), 1);
        check("stuck_err_cyc", (ec.size() > 0) ? ec[0] : -1, last_rise + THM + 3);
        check("stuck_nvalid", vq.size(), 0);
        check("stuck_nframe", fc.size(), 1);
        check("stuck_frame_cyc", (fc.size() > 0) ? fc[0] : -1, last_fall + TR + 3);
        clear();

        // Reset in the middle of a word
        send_word(24'($urandom), 12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", 32'(data), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_frame_end", 32'(frame_end), 0);
        check("mid_rst_err", 32'(err), 0);
        repeat (20) @(negedge clk);
        send_word(24'hABCDEF, 24);
        gap();
        check("mid_rst_nvalid", vq.size(), 1);
        check("mid_rst_word", (vq.size() > 0) ? 32'(vq[0]) : 32'hdead, 32'hABCDEF);
        check("mid_rst_nerr", ec.size(), 0);
        check("mid_rst_nframe", fc.size(), 1);
        clear();

        // Randomized widths: the model classifies each pulse by its width alone
        for (int k = 0; k < 4; k++) begin
            exp_w = 24'($urandom);
            words[k] = '0;
            for (int i = 23; i >= 0; i--) begin
                hi = exp_w[i] ? int'($urandom_range(95, 30)) : int'($urandom_range(29, 4));
                lo = int'($urandom_range(60, 4));
                words[k] = {words[k][22:0], hi >= T1};
                send_bit(hi >= T1, hi, lo);
            end
        end
        gap();
        check("rnd_nvalid", vq.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("rnd_word%0d", k), (vq.size() > k) ? 32'(vq[k]) : 32'hdead, 32'(words[k]));
        check("rnd_nframe", fc.size(), 1);
        check("rnd_nerr", ec.size(), 0);
        check("data_hold", hold_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ws2812_receiver.md
# ws2812_receiver

Single-wire NRZ LED-protocol decoder: the receive-side counterpart of the team's 24-bit MSB-first serializer/shift-register transmitter. It samples the serial LED data line, classifies each high pulse as a 0 or 1 by its width, reassembles W-bit words MSB-first, and detects the low reset/latch gap that ends a frame. It is used for loopback self-test of the LED driver chain and for decoding a daisy-chained upstream controller.

## Interface
- W, 24, bits per word (GRB pixel).
- T1_MIN, 30, minimum high width in clk cycles classified as a 1 bit. Shorter pulses are 0 bits.
- T_HIGH_MAX, 100, high width in cycles at which the line is declared stuck high.
- T_RESET, 2500, low width in cycles that terminates a frame (50 us at 50 MHz).
- CNT_W, 12, width of the pulse-width counters. Must hold T_RESET.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  asynchronous serial LED data line.
- data  out  W  last complete word, MSB = first bit received. Held until the next word completes.
- valid  out  1  one-cycle pulse; data updated this cycle.
- frame_end  out  1  one-cycle pulse; reset gap detected after at least one bit.
- err  out  1  one-cycle pulse; partial word at gap, or stuck-high line.

## Operation
- **Input stage:** din passes through a 2-flop synchronizer to din_s, then one more flop to din_p. Both reset to 1.
  - rise = din_s & ~din_p
  - fall = ~din_s & din_p
- **Counters and registers:**
  - hcnt counts high cycles; it loads 1 on rise.
  - lcnt counts low cycles; it loads 1 on fall.
  - Both saturate at all-ones and never wrap.
  - shreg (W bits) collects bits. bcnt (clog2(W+1) bits) counts bits in the current word.
  - got_bit is set when any bit is accepted and cleared on frame_end.
- **IDLE:** line low, no frame activity. On rise, go to HIGH.
- **HIGH:** hcnt increments each cycle din_s = 1.
  - On fall: accept bit b = (hcnt >= T1_MIN). Shift shreg left, inserting b at LSB. Go to LOW.
  - When bcnt reaches W-1 before the increment, the word is complete:
    - data <= {shreg[W-2:0], b}
    - valid = 1
    - bcnt <= 0
  - If hcnt reaches T_HIGH_MAX, pulse err, discard the partial word (bcnt <= 0), and go to STUCK.
- **LOW:** lcnt increments each cycle din_s = 0.
  - On rise, go to HIGH. Word assembly continues across bits.
  - When lcnt == T_RESET (exactly once per gap):
    - If got_bit = 1, pulse frame_end.
    - If bcnt != 0, also pulse err and set bcnt <= 0.
    - Go to IDLE.
- **STUCK:** wait for fall, then go to LOW with lcnt = 1. No bit is accepted from the stuck pulse.
- **Rise on the same cycle lcnt == T_RESET:**
  - frame_end/err fire for the old frame.
  - The rise starts a new bit: state goes to HIGH, hcnt = 1.
- **Reset behaviour:**
  - State IDLE; counters, shreg, bcnt and got_bit cleared.
  - data = 0, valid = 0, frame_end = 0, err = 0.
  - A line held high across reset produces no rise, so no false bit.
  - Reset mid-word discards the partial word silently; no err.
- **Data hold:** data never changes except when valid = 1.

## Timing
- din_s lags din by 2 cycles. rise/fall are combinational on din_s/din_p.
- Bit width seen by the decoder = number of cycles din_s is high.
- valid asserts in the cycle after the cycle in which fall of bit W is seen, i.e. 3 clk after din falls.
- frame_end asserts T_RESET cycles after fall is seen (first low cycle counts as 1), plus 1 register cycle.
- err (stuck) asserts 1 cycle after hcnt reaches T_HIGH_MAX.
- valid and frame_end may assert in the same cycle only if the gap follows directly. In practice they are at least T_RESET apart.
- All outputs are registered. No combinational path from din to outputs.
- Minimum supported bit period is 4 cycles high + 4 cycles low.

## Test plan
- **Single word:** encode 0xA5C3F0 (0 bit = 20 high / 42 low; 1 bit = 40 high / 22 low), then 2600 cycles low.
  - valid exactly once with data = 0xA5C3F0.
  - frame_end once, 2500 cycles after the last fall; err never.
- **Back-to-back words:** send 0x00FF00 then 0xFFFFFF, then the gap.
  - Two valid pulses, in order.
  - One frame_end; data holds 0xFFFFFF afterward.
- **Threshold boundary:** 24 bits alternating 29- and 30-cycle highs.
  - data = 0x555555.
- **Partial word:** 10 bits, then the gap.
  - No valid; err and frame_end in the same cycle.
  - The next full word 0x123456 decodes correctly.
- **Stuck high:** din high 150 cycles after 5 good bits, then low 2600 cycles.
  - err once at hcnt = 100; no bit accepted; no valid.
  - frame_end without a second err.
- **Reset mid-word:** assert rst for 1 cycle after 12 bits.
  - All outputs 0; no err.
  - The following word 0xABCDEF gives valid with data = 0xABCDEF.
